// File: rtl/fft_stage_twiddle_ctrl_if.sv
// Bus between the stage sequencer, the data RAM / multComplexE pair and the twiddle controller.
// The controller connects through the slave modport.
interface fft_stage_twiddle_ctrl_if #(
  parameter int unsigned SIZE_DATA_FI = 4,
  parameter int unsigned STAGE_W      = 3
);
  logic                    start;
  logic [STAGE_W-1:0]      stage;
  logic                    hold;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    rd_en;
  logic [SIZE_DATA_FI-1:0] rd_addr_a;
  logic [SIZE_DATA_FI-1:0] rd_addr_b;
  logic                    mult_en;
  logic [SIZE_DATA_FI-1:0] mult_fi;
  logic                    mult_valid;
  logic                    wr_en;
  logic [SIZE_DATA_FI-1:0] wr_addr_a;
  logic [SIZE_DATA_FI-1:0] wr_addr_b;

  modport slave (
    input  start, stage, hold, mult_valid,
    output busy, done, err, rd_en, rd_addr_a, rd_addr_b,
           mult_en, mult_fi, wr_en, wr_addr_a, wr_addr_b
  );

  modport master (
    output start, stage, hold, mult_valid,
    input  busy, done, err, rd_en, rd_addr_a, rd_addr_b,
           mult_en, mult_fi, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_stage_twiddle_ctrl.sv
// Sequences one radix-2 DIF FFT stage through the shared twiddle multiplier:
// issues read addresses / phase per butterfly and write-back addresses as results return.
module fft_stage_twiddle_ctrl #(
  parameter int unsigned SIZE_DATA_FI = 4,
  parameter int unsigned STAGE_W      = 3,
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  fft_stage_twiddle_ctrl_if.slave bus
);
  localparam int unsigned AW  = SIZE_DATA_FI;
  localparam int unsigned AW2 = 2 * SIZE_DATA_FI;
  localparam int unsigned AW3 = 3 * SIZE_DATA_FI;
  localparam int unsigned NB  = 1 << (SIZE_DATA_FI - 1);
  localparam int unsigned IW  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STAGE_W-1:0] r_s;
  logic [AW-1:0]      r_k;
  logic [AW-1:0]      r_wr_k;
  logic [IW-1:0]      r_inflight;

  logic               w_accept;
  logic               w_bad_start;
  logic               w_issue;
  logic               w_last_issue;
  logic               w_wr_ok;
  logic               w_spurious;
  logic [AW3-1:0]     w_rd_vec;
  logic [AW2-1:0]     w_wr_ab;

  // {addr_a, addr_b, fi}: high bits of k above the butterfly span are doubled, low bits are j.
  function automatic logic [AW3-1:0] bfly_addr(input logic [AW-1:0] k, input logic [STAGE_W-1:0] s);
    logic [AW-1:0] half;
    logic [AW-1:0] mask;
    logic [AW-1:0] j;
    logic [AW-1:0] a;
    half = AW'(1) << (STAGE_W'(AW - 1) - s);
    mask = half - AW'(1);
    j    = k & mask;
    a    = ((k & ~mask) << 1) | j;
    return {a, a | half, j << s};
  endfunction

  assign w_rd_vec = bfly_addr(r_k, r_s);
  assign w_wr_ab  = AW2'(bfly_addr(r_wr_k, r_s) >> AW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_inflight == '0) && !bus.mult_valid) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = 1'b0;
    w_bad_start = 1'b0;
    w_issue     = 1'b0;
    w_wr_ok     = bus.mult_valid && (r_inflight != '0);
    w_spurious  = bus.mult_valid && (r_inflight == '0);
    case (r_state)
      S_IDLE: begin
        w_accept    = bus.start && (bus.stage <  STAGE_W'(SIZE_DATA_FI));
        w_bad_start = bus.start && (bus.stage >= STAGE_W'(SIZE_DATA_FI));
      end
      S_ISSUE: w_issue = !bus.hold && (r_inflight < IW'(MAX_INFLIGHT));
      default: ;
    endcase
    w_last_issue = w_issue && (r_k == AW'(NB - 1));
  end

  // Registered outputs, counters and the in-flight tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.rd_en     <= 1'b0;
      bus.mult_en   <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.rd_addr_a <= '0;
      bus.rd_addr_b <= '0;
      bus.mult_fi   <= '0;
      bus.wr_addr_a <= '0;
      bus.wr_addr_b <= '0;
      r_s           <= '0;
      r_k           <= '0;
      r_wr_k        <= '0;
      r_inflight    <= '0;
    end else begin
      bus.busy    <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
      bus.done    <= (w_state_nxt == S_DONE);
      bus.rd_en   <= w_issue;
      bus.mult_en <= w_issue;
      bus.wr_en   <= w_wr_ok;
      if (w_accept) begin
        r_s    <= bus.stage;
        r_k    <= '0;
        r_wr_k <= '0;
      end
      if (w_issue) begin
        {bus.rd_addr_a, bus.rd_addr_b, bus.mult_fi} <= w_rd_vec;
        r_k <= r_k + AW'(1);
      end
      if (w_wr_ok) begin
        {bus.wr_addr_a, bus.wr_addr_b} <= w_wr_ab;
        r_wr_k <= r_wr_k + AW'(1);
      end
      if (w_accept) r_inflight <= '0;
      else          r_inflight <= r_inflight + IW'(w_issue) - IW'(w_wr_ok);
      if (w_spurious || w_bad_start) bus.err <= 1'b1;
      else if (w_accept)             bus.err <= 1'b0;
    end
  end
endmodule
